// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the forward-NTT twiddle/index address generator.
package ntt_pkg;
  localparam int N             = 256;
  localparam int Q             = 3329;
  localparam int NUM_BU        = 8;
  localparam int NUM_LAYERS    = 7;
  localparam int CYC_PER_LAYER = 16;
  localparam int ADDR_WIDTH    = 7;
  localparam int IDX_WIDTH     = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/ntt_bu_addr.sv
// Twiddle address and butterfly operand indices for one butterfly unit, from the layer/cycle counters.
module ntt_bu_addr
  import ntt_pkg::*;
#(
  parameter int BU         = 0,
  parameter int WIDTH_ADDR = ADDR_WIDTH,
  parameter int WIDTH_IDX  = IDX_WIDTH
) (
  input  logic [2:0]            layer_i,
  input  logic [3:0]            cyc_i,
  output logic [WIDTH_ADDR-1:0] address_o,
  output logic [WIDTH_IDX-1:0]  idx_top_o,
  output logic [WIDTH_IDX-1:0]  idx_bot_o
);
  localparam logic [2:0] BU_NUM = 3'(BU);

  logic [WIDTH_ADDR-1:0] j;
  logic [WIDTH_ADDR-1:0] g;
  logic [WIDTH_ADDR-1:0] i;
  logic [WIDTH_IDX-1:0]  len;
  logic [WIDTH_IDX-1:0]  top;

  always_comb begin
    j   = {cyc_i, BU_NUM};
    len = WIDTH_IDX'(N / 2) >> layer_i;
    g   = j >> (3'd7 - layer_i);
    i   = j & WIDTH_ADDR'(len - 1'b1);
    // group base g*2*len is a shift since len is a power of two
    top = ({1'b0, g} << (4'd8 - {1'b0, layer_i})) + {1'b0, i};
    address_o = WIDTH_ADDR'(1'b1) << layer_i;
    address_o = address_o + g;
    idx_top_o = top;
    idx_bot_o = top + len;
  end
endmodule

// File: rtl/ntt_addr_gen.sv
// Sequences one forward NTT pass: 7 layers x 16 cycles, 8 butterflies per cycle, with stall hold.
module ntt_addr_gen #(
  parameter int NUM_BU     = 8,
  parameter int WIDTH_ADDR = 7,
  parameter int WIDTH_IDX  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stall_i,
  output logic [WIDTH_ADDR-1:0] address0,
  output logic [WIDTH_ADDR-1:0] address1,
  output logic [WIDTH_ADDR-1:0] address2,
  output logic [WIDTH_ADDR-1:0] address3,
  output logic [WIDTH_ADDR-1:0] address4,
  output logic [WIDTH_ADDR-1:0] address5,
  output logic [WIDTH_ADDR-1:0] address6,
  output logic [WIDTH_ADDR-1:0] address7,
  output logic [WIDTH_IDX-1:0]  idx_top0,
  output logic [WIDTH_IDX-1:0]  idx_top1,
  output logic [WIDTH_IDX-1:0]  idx_top2,
  output logic [WIDTH_IDX-1:0]  idx_top3,
  output logic [WIDTH_IDX-1:0]  idx_top4,
  output logic [WIDTH_IDX-1:0]  idx_top5,
  output logic [WIDTH_IDX-1:0]  idx_top6,
  output logic [WIDTH_IDX-1:0]  idx_top7,
  output logic [WIDTH_IDX-1:0]  idx_bot0,
  output logic [WIDTH_IDX-1:0]  idx_bot1,
  output logic [WIDTH_IDX-1:0]  idx_bot2,
  output logic [WIDTH_IDX-1:0]  idx_bot3,
  output logic [WIDTH_IDX-1:0]  idx_bot4,
  output logic [WIDTH_IDX-1:0]  idx_bot5,
  output logic [WIDTH_IDX-1:0]  idx_bot6,
  output logic [WIDTH_IDX-1:0]  idx_bot7,
  output logic [2:0]            layer_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  done_o
);
  import ntt_pkg::*;

  state_e     state_q, state_d;
  logic [2:0] layer_q, layer_d;
  logic [3:0] cyc_q,   cyc_d;

  logic [WIDTH_ADDR-1:0] addr_w [8];
  logic [WIDTH_IDX-1:0]  top_w  [8];
  logic [WIDTH_IDX-1:0]  bot_w  [8];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN: begin
        if (!stall_i) begin
          if (cyc_q == 4'(CYC_PER_LAYER - 1)) begin
            cyc_d = '0;
            if (layer_q == 3'(NUM_LAYERS - 1)) begin
              layer_d = '0;
              state_d = S_DONE;
            end else begin
              layer_d = layer_q + 3'd1;
            end
          end else begin
            cyc_d = cyc_q + 4'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // flags are forced low while reset is asserted, not only after the edge
  always_comb begin
    valid_o = !rst_i && (state_q == S_RUN) && !stall_i;
    busy_o  = !rst_i && (state_q != S_IDLE);
    done_o  = !rst_i && (state_q == S_DONE);
    layer_o = rst_i ? 3'd0 : layer_q;
  end

  for (genvar b = 0; b < NUM_BU; b++) begin : g_bu
    ntt_bu_addr #(
      .BU        (b),
      .WIDTH_ADDR(WIDTH_ADDR),
      .WIDTH_IDX (WIDTH_IDX)
    ) u_bu (
      .layer_i  (layer_q),
      .cyc_i    (cyc_q),
      .address_o(addr_w[b]),
      .idx_top_o(top_w[b]),
      .idx_bot_o(bot_w[b])
    );
  end

  assign address0 = addr_w[0];
  assign address1 = addr_w[1];
  assign address2 = addr_w[2];
  assign address3 = addr_w[3];
  assign address4 = addr_w[4];
  assign address5 = addr_w[5];
  assign address6 = addr_w[6];
  assign address7 = addr_w[7];
  assign idx_top0 = top_w[0];
  assign idx_top1 = top_w[1];
  assign idx_top2 = top_w[2];
  assign idx_top3 = top_w[3];
  assign idx_top4 = top_w[4];
  assign idx_top5 = top_w[5];
  assign idx_top6 = top_w[6];
  assign idx_top7 = top_w[7];
  assign idx_bot0 = bot_w[0];
  assign idx_bot1 = bot_w[1];
  assign idx_bot2 = bot_w[2];
  assign idx_bot3 = bot_w[3];
  assign idx_bot4 = bot_w[4];
  assign idx_bot5 = bot_w[5];
  assign idx_bot6 = bot_w[6];
  assign idx_bot7 = bot_w[7];
endmodule

// File: tb/tb_ntt_addr_gen.sv
// Self-checking bench for ntt_addr_gen against a Kyber-loop reference table and pass-level bookkeeping.
module tb_ntt_addr_gen;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic stall_i = 1'b0;
  logic [6:0] addr_w [8];
  logic [7:0] top_w  [8];
  logic [7:0] bot_w  [8];
  logic [2:0] layer_o;
  logic valid_o, busy_o, done_o;

  always #5 clk = ~clk;

  ntt_addr_gen dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .address0(addr_w[0]), .address1(addr_w[1]), .address2(addr_w[2]), .address3(addr_w[3]),
    .address4(addr_w[4]), .address5(addr_w[5]), .address6(addr_w[6]), .address7(addr_w[7]),
    .idx_top0(top_w[0]), .idx_top1(top_w[1]), .idx_top2(top_w[2]), .idx_top3(top_w[3]),
    .idx_top4(top_w[4]), .idx_top5(top_w[5]), .idx_top6(top_w[6]), .idx_top7(top_w[7]),
    .idx_bot0(bot_w[0]), .idx_bot1(bot_w[1]), .idx_bot2(bot_w[2]), .idx_bot3(bot_w[3]),
    .idx_bot4(bot_w[4]), .idx_bot5(bot_w[5]), .idx_bot6(bot_w[6]), .idx_bot7(bot_w[7]),
    .layer_o(layer_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  int tests = 0;
  int failed = 0;

  // reference butterfly schedule, one entry per butterfly in issue order
  int ref_addr [7][128];
  int ref_top  [7][128];
  int ref_bot  [7][128];

  // pass-level model: ph 0=idle 1=run 2=done, pos = butterfly-cycle index within the pass
  int ph = 0;
  int pos = 0;
  int ncyc = 0;
  int start_edge = 0;
  int done_edge = 0;
  int valid_cnt = 0;
  int done_cnt = 0;
  int hist [128];

  int a_l3 = 10;
  int a_l6 [8] = '{64, 64, 65, 65, 66, 66, 67, 67};
  int t_l6 [8] = '{0, 1, 4, 5, 8, 9, 12, 13};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic build_ref();
    int k, len, t;
    k = 1;
    for (int l = 0; l < 7; l++) begin
      len = 128 >> l;
      t = 0;
      for (int start = 0; start < 256; start += 2 * len) begin
        for (int j = start; j < start + len; j++) begin
          ref_addr[l][t] = k;
          ref_top[l][t]  = j;
          ref_bot[l][t]  = j + len;
          t++;
        end
        k++;
      end
    end
  endtask

  task automatic clear_tally();
    valid_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 128; k++) hist[k] = 0;
  endtask

  task automatic check(input logic rs, input logic sl);
    int ptr, l, c, t;
    ptr = (ph == 1) ? pos : 0;
    l = ptr / 16;
    c = ptr % 16;
    chk("valid", 32'(valid_o), 32'(!rs && ph == 1 && !sl));
    chk("busy",  32'(busy_o),  32'(!rs && ph != 0));
    chk("done",  32'(done_o),  32'(!rs && ph == 2));
    chk("layer", 32'(layer_o), rs ? 32'd0 : 32'(l));
    for (int b = 0; b < 8; b++) begin
      t = c * 8 + b;
      chk($sformatf("addr%0d@%0d", b, ptr), 32'(addr_w[b]), 32'(ref_addr[l][t]));
      chk($sformatf("top%0d@%0d", b, ptr),  32'(top_w[b]),  32'(ref_top[l][t]));
      chk($sformatf("bot%0d@%0d", b, ptr),  32'(bot_w[b]),  32'(ref_bot[l][t]));
    end
    if (ph == 1 && pos == 3 * 16 + 5 && !rs) begin
      for (int b = 0; b < 8; b++) begin
        chk("l3c5_addr", 32'(addr_w[b]), 32'(a_l3));
        chk("l3c5_top",  32'(top_w[b]),  32'(72 + b));
        chk("l3c5_bot",  32'(bot_w[b]),  32'(88 + b));
      end
    end
    if (ph == 1 && pos == 6 * 16 && !rs) begin
      for (int b = 0; b < 8; b++) begin
        chk("l6c0_addr", 32'(addr_w[b]), 32'(a_l6[b]));
        chk("l6c0_top",  32'(top_w[b]),  32'(t_l6[b]));
        chk("l6c0_bot",  32'(bot_w[b]),  32'(t_l6[b] + 2));
      end
    end
    if (valid_o === 1'b1) begin
      valid_cnt++;
      for (int b = 0; b < 8; b++) hist[addr_w[b]]++;
    end
    if (done_o === 1'b1) begin
      done_cnt++;
      done_edge = ncyc;
    end
  endtask

  task automatic cycle(input logic st, input logic sl, input logic rs);
    @(negedge clk);
    start_i = st;
    stall_i = sl;
    rst_i = rs;
    #1;
    check(rs, sl);
    @(posedge clk);
    ncyc++;
    if (rs) begin
      ph = 0;
      pos = 0;
    end else begin
      case (ph)
        0: if (st) begin ph = 1; pos = 0; start_edge = ncyc; end
        1: if (!sl) begin
             pos++;
             if (pos == 112) begin ph = 2; pos = 0; end
           end
        default: ph = 0;
      endcase
    end
  endtask

  // mode 0: no stall; 1: 3-cycle stall at layer 2 cyc 7 plus stray starts; 2: random stalls/starts
  task automatic run_pass(input int mode);
    int guard, stalls;
    logic st, sl;
    clear_tally();
    stalls = 0;
    cycle(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (ph != 0 && guard < 1000) begin
      st = 1'b0;
      sl = 1'b0;
      if (mode == 1) begin
        sl = (ph == 1 && pos == 2 * 16 + 7 && stalls < 3);
        st = (ph == 2) || (ph == 1 && pos == 20);
      end else if (mode == 2) begin
        sl = ($urandom_range(0, 3) == 0);
        st = ($urandom_range(0, 7) == 0);
      end
      if (sl && ph == 1) stalls++;
      cycle(st, sl, 1'b0);
      guard++;
    end
    chk("pass_terminates", 32'(guard < 1000), 32'd1);
    chk("valid_cycles", 32'(valid_cnt), 32'd112);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_latency", 32'(done_edge - start_edge), 32'(112 + stalls));
    // each zeta in layer l serves 128>>l butterflies
    for (int k = 1; k < 128; k++)
      chk($sformatf("zeta_use%0d", k), 32'(hist[k]), 32'(128 >> ($clog2(k + 1) - 1)));
    chk("zeta_use0", 32'(hist[0]), 32'd0);
  endtask

  initial begin
    build_ref();
    @(posedge clk);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);

    run_pass(0);
    cycle(1'b0, 1'b1, 1'b0);
    run_pass(1);
    cycle(1'b0, 1'b0, 1'b0);
    run_pass(2);
    run_pass(2);

    // abort mid-run at layer 4 cyc 9
    clear_tally();
    cycle(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 200 && !(ph == 1 && pos == 4 * 16 + 9); n++) cycle(1'b0, 1'b0, 1'b0);
    chk("abort_reached", 32'(pos), 32'(4 * 16 + 9));
    cycle(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 8; n++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_pass(0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
